// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit frames sent MSB-first or LSB-first.
// Optional even-parity trailer bit enabled by defining DESER_PARITY_EN.
module shift_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             start,
    input  logic             dir,
    input  logic             ack,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;

    logic             done;
    logic             perr_calc;

    // dr=0 matches a right-shift sender (LSB first), dr=1 a left-shift sender (MSB first).
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b, input logic dr);
        if (dr)
            return {cur[WIDTH-2:0], b};
        else
            return {b, cur[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        done      = 1'b0;
        perr_calc = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = dir;
                    sr_d    = shift_in(sr_q, sin, dir);
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CW'(1);
`ifdef DESER_PARITY_EN
                // Trailing parity bit is checked but never enters the shift register.
                if (cnt_q == CW'(WIDTH)) begin
                    done      = 1'b1;
                    perr_calc = (^sr_q) ^ sin;
                end else begin
                    sr_d = shift_in(sr_q, sin, d_q);
                end
`else
                sr_d = shift_in(sr_q, sin, d_q);
                if (cnt_q == CW'(WIDTH - 1))
                    done = 1'b1;
`endif
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (!valid_q || ack) begin
                q_d     = sr_d;
                valid_d = 1'b1;
                perr_d  = perr_calc;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            d_q       <= 1'b0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign Q          = q_q;
    assign valid      = valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;
    assign parity_err = perr_q;

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that reassembles words sent bit-serially by a shift-register transmitter, in either shift direction. Captures a framed serial stream of WIDTH bits, MSB-first or LSB-first, selected per frame. Presents the word on a registered parallel output held under a valid/ack handshake. Sits at the receive end of a serial link, feeding parallel consumers: registers, counters, display logic.

## Interface
- WIDTH, 4, data bits per frame; legal range 2 to 16.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit, sampled every rising edge while a frame is active.
- start  input  1  frame strobe, high in the same cycle as the first data bit; ignored unless the FSM is IDLE.
- dir  input  1  sampled with start and latched for the frame. 0 = LSB-first (right-shift sender). 1 = MSB-first (left-shift sender).
- ack  input  1  consumer accepts Q; clears valid at the edge where ack=1.
- Q  output  WIDTH  last completed word, registered.
- valid  output  1  Q holds an unconsumed word.
- busy  output  1  frame in progress (FSM in SHIFT).
- overrun  output  1  sticky; a completed word was dropped because valid=1 and ack=0.
- parity_err  output  1  parity result for the word in Q (see Configuration).

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt of width clog2(WIDTH+1), latched direction d, FSM with states IDLE and SHIFT.
- Shift rule for each sampled bit:
  - d=0: sr <= {sin, sr[WIDTH-1:1]}.
  - d=1: sr <= {sr[WIDTH-2:0], sin}.
- IDLE:
  - start=1: d <= dir, shift in sin using dir, cnt <= 1, go to SHIFT.
  - start=0: hold all state.
- SHIFT:
  - Each cycle shift in sin and increment cnt. start is ignored.
  - The cycle where the final frame bit is sampled (cnt = FRAME-1, FRAME = WIDTH, or WIDTH+1 with parity) completes the frame and returns to IDLE.
  - The next cycle may carry a new start, so back-to-back frames need no gap.
- Completion, when the last data bit is shifted in:
  - valid=0, or ack=1 in the same cycle: Q <= assembled word, valid <= 1.
  - valid=1 and ack=0: word dropped, Q unchanged, overrun <= 1.
- ack=1 with no completion: valid <= 0, overrun <= 0. Q holds its value.
- ack while valid=0 has no effect.
- busy = (state == SHIFT).

## Timing
- Reset: state IDLE, sr=0, cnt=0, d=0, Q=0, valid=0, busy=0, overrun=0, parity_err=0.
- rst overrides all other inputs in the same edge. Reset mid-frame discards the partial word; start in the first cycle after reset is accepted.
- Latency: valid and Q update at the edge that samples the last frame bit. They are visible in the cycle after that bit is presented.
- A frame occupies exactly FRAME consecutive cycles, with start in the first of them.
- sin and start must be stable around the rising edge. The block uses no internal synchronizer.

## Configuration
- DESER_PARITY_EN defined:
  - FRAME = WIDTH+1; one even-parity bit follows the data bits and is not shifted into sr.
  - parity_err <= (XOR of data bits XOR parity bit) and is loaded together with Q.
  - When a word is dropped for overrun, parity_err is unchanged.
- DESER_PARITY_EN undefined: FRAME = WIDTH, and parity_err is constant 0.

## Test plan
- WIDTH=4, dir=1, sin=1,0,1,1 over 4 cycles, start in cycle 0 -> Q=4'b1011, valid=1 after cycle-3 edge, busy high cycles 1–3.
- dir=0, same sin sequence -> Q=4'b1101, valid=1.
- Two frames back-to-back (0xA then 0x5, dir=1); ack pulsed after first valid -> Q=4'hA then 4'h5, no overrun.
- Two frames with ack held 0 -> Q stays 4'hA, overrun=1 after second frame; then ack=1 -> valid=0, overrun=0.
- rst=1 in cycle 2 of a frame, then new frame 4'b0110 -> Q=4'b0110; partial bits absent; reset values checked on all outputs.
- DESER_PARITY_EN, data 1011 with parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1.
